// File: rtl/proc_io_hub.sv
// Buffered I/O hub between a proc_fx core and NUIOIN input / NUIOOU output channels, one FIFO per channel.
// Optional status word at input address NUIOIN is enabled by defining IOHUB_STATUS_EN.
module proc_io_hub #(
  parameter int NUBITS = 31,
  parameter int NUIOIN = 4,
  parameter int NUIOOU = 4,
  parameter int FDEPTH = 4,
  parameter int IAW    = $clog2(NUIOIN + 1),
  parameter int OAW    = (NUIOOU > 1) ? $clog2(NUIOOU) : 1
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       proc_req_in,
  input  logic [IAW-1:0]             addr_in,
  output logic [NUBITS-1:0]          proc_in,
  input  logic                       proc_out_en,
  input  logic [OAW-1:0]             addr_out,
  input  logic [NUBITS-1:0]          proc_out,
  input  logic [NUIOIN*NUBITS-1:0]   ext_in_data,
  input  logic [NUIOIN-1:0]          ext_in_valid,
  output logic [NUIOIN-1:0]          ext_in_ready,
  output logic [NUIOOU*NUBITS-1:0]   ext_out_data,
  output logic [NUIOOU-1:0]          ext_out_valid,
  input  logic [NUIOOU-1:0]          ext_out_ready,
  output logic [NUIOIN-1:0]          unf_flag,
  output logic [NUIOOU-1:0]          ovf_flag
);

  localparam int PW = $clog2(FDEPTH);
  localparam int CW = PW + 1;
  localparam int SW = 2 * (NUIOIN + NUIOOU);

`ifdef IOHUB_STATUS_EN
  localparam bit STATUS_EN = 1'b1;
`else
  localparam bit STATUS_EN = 1'b0;
`endif

  typedef logic [NUBITS-1:0] word_t;

  // Handshake: a word moves on a channel in any cycle where valid and ready are both high at posedge.
  word_t         in_mem_q   [NUIOIN][FDEPTH];
  word_t         in_mem_d   [NUIOIN][FDEPTH];
  logic [PW-1:0] in_wptr_q  [NUIOIN];
  logic [PW-1:0] in_wptr_d  [NUIOIN];
  logic [PW-1:0] in_rptr_q  [NUIOIN];
  logic [PW-1:0] in_rptr_d  [NUIOIN];
  logic [CW-1:0] in_cnt_q   [NUIOIN];
  logic [CW-1:0] in_cnt_d   [NUIOIN];
  word_t         in_hold_q  [NUIOIN];
  word_t         in_hold_d  [NUIOIN];

  word_t         out_mem_q  [NUIOOU][FDEPTH];
  word_t         out_mem_d  [NUIOOU][FDEPTH];
  logic [PW-1:0] out_wptr_q [NUIOOU];
  logic [PW-1:0] out_wptr_d [NUIOOU];
  logic [PW-1:0] out_rptr_q [NUIOOU];
  logic [PW-1:0] out_rptr_d [NUIOOU];
  logic [CW-1:0] out_cnt_q  [NUIOOU];
  logic [CW-1:0] out_cnt_d  [NUIOOU];

  logic [NUIOIN-1:0] unf_q, unf_d;
  logic [NUIOOU-1:0] ovf_q, ovf_d;

  logic [NUIOIN-1:0] in_full, in_push, in_pop, in_under, in_sel;
  logic [NUIOOU-1:0] out_full, out_empty, out_wr, out_push, out_pop, out_drop;
  logic [SW-1:0]     status_word;
  logic              status_sel;
  logic              status_rd;

  always_comb begin : in_ctrl
    in_full  = '0;
    in_sel   = '0;
    in_push  = '0;
    in_pop   = '0;
    in_under = '0;
    for (int i = 0; i < NUIOIN; i++) begin
      in_full[i]  = (in_cnt_q[i] == CW'(FDEPTH));
      in_sel[i]   = proc_req_in && (addr_in == IAW'(i));
      // ready depends only on full, so a full FIFO refuses a push even when it pops
      in_push[i]  = ext_in_valid[i] && !in_full[i];
      in_pop[i]   = in_sel[i] && (in_cnt_q[i] != '0);
      in_under[i] = in_sel[i] && (in_cnt_q[i] == '0);
    end
  end

  always_comb begin : out_ctrl
    out_full  = '0;
    out_empty = '0;
    out_wr    = '0;
    out_pop   = '0;
    out_push  = '0;
    out_drop  = '0;
    for (int j = 0; j < NUIOOU; j++) begin
      out_full[j]  = (out_cnt_q[j] == CW'(FDEPTH));
      out_empty[j] = (out_cnt_q[j] == '0);
      out_wr[j]    = proc_out_en && (addr_out == OAW'(j));
      out_pop[j]   = !out_empty[j] && ext_out_ready[j];
      // a full FIFO that pops in the same cycle still has room for the core's word
      out_push[j]  = out_wr[j] && (!out_full[j] || out_pop[j]);
      out_drop[j]  = out_wr[j] && out_full[j] && !out_pop[j];
    end
  end

  always_comb begin : status_logic
    status_word = {ovf_q, unf_q, ~ext_out_valid, ~ext_in_ready};
    status_sel  = STATUS_EN && (addr_in == IAW'(NUIOIN));
    status_rd   = status_sel && proc_req_in;
  end

  always_comb begin : in_next
    in_mem_d  = in_mem_q;
    in_wptr_d = in_wptr_q;
    in_rptr_d = in_rptr_q;
    in_cnt_d  = in_cnt_q;
    in_hold_d = in_hold_q;
    for (int i = 0; i < NUIOIN; i++) begin
      if (in_push[i]) begin
        in_mem_d[i][in_wptr_q[i]] = ext_in_data[i*NUBITS +: NUBITS];
        in_wptr_d[i]              = in_wptr_q[i] + PW'(1);
      end
      if (in_pop[i]) begin
        in_hold_d[i] = in_mem_q[i][in_rptr_q[i]];
        in_rptr_d[i] = in_rptr_q[i] + PW'(1);
      end
      in_cnt_d[i] = in_cnt_q[i] + CW'(in_push[i]) - CW'(in_pop[i]);
    end
  end

  always_comb begin : out_next
    out_mem_d  = out_mem_q;
    out_wptr_d = out_wptr_q;
    out_rptr_d = out_rptr_q;
    out_cnt_d  = out_cnt_q;
    for (int j = 0; j < NUIOOU; j++) begin
      if (out_push[j]) begin
        out_mem_d[j][out_wptr_q[j]] = proc_out;
        out_wptr_d[j]               = out_wptr_q[j] + PW'(1);
      end
      if (out_pop[j]) begin
        out_rptr_d[j] = out_rptr_q[j] + PW'(1);
      end
      out_cnt_d[j] = out_cnt_q[j] + CW'(out_push[j]) - CW'(out_pop[j]);
    end
  end

  // A flag raised in the cycle of a status read survives the clear
  always_comb begin : flag_next
    unf_d = (unf_q & ~{NUIOIN{status_rd}}) | in_under;
    ovf_d = (ovf_q & ~{NUIOOU{status_rd}}) | out_drop;
  end

  always_comb begin : proc_read
    proc_in = '0;
    for (int i = 0; i < NUIOIN; i++) begin
      if (addr_in == IAW'(i)) begin
        proc_in = (in_cnt_q[i] != '0) ? in_mem_q[i][in_rptr_q[i]] : in_hold_q[i];
      end
    end
    if (status_sel) begin
      proc_in = NUBITS'(status_word);
    end
  end

  always_comb begin : ext_drive
    ext_in_ready  = ~in_full;
    ext_out_valid = ~out_empty;
    ext_out_data  = '0;
    for (int j = 0; j < NUIOOU; j++) begin
      ext_out_data[j*NUBITS +: NUBITS] = out_mem_q[j][out_rptr_q[j]];
    end
    unf_flag = unf_q;
    ovf_flag = ovf_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      in_mem_q   <= '{default: '0};
      in_wptr_q  <= '{default: '0};
      in_rptr_q  <= '{default: '0};
      in_cnt_q   <= '{default: '0};
      in_hold_q  <= '{default: '0};
      out_mem_q  <= '{default: '0};
      out_wptr_q <= '{default: '0};
      out_rptr_q <= '{default: '0};
      out_cnt_q  <= '{default: '0};
      unf_q      <= '0;
      ovf_q      <= '0;
    end else begin
      in_mem_q   <= in_mem_d;
      in_wptr_q  <= in_wptr_d;
      in_rptr_q  <= in_rptr_d;
      in_cnt_q   <= in_cnt_d;
      in_hold_q  <= in_hold_d;
      out_mem_q  <= out_mem_d;
      out_wptr_q <= out_wptr_d;
      out_rptr_q <= out_rptr_d;
      out_cnt_q  <= out_cnt_d;
      unf_q      <= unf_d;
      ovf_q      <= ovf_d;
    end
  end

endmodule

// File: tb/tb_proc_io_hub.sv
// Bench for proc_io_hub: directed scenarios with literal expectations, then random traffic
// checked every cycle against a queue-based model of the channels.
module tb_proc_io_hub;

  localparam int NUBITS = 31;
  localparam int NUIOIN = 4;
  localparam int NUIOOU = 4;
  localparam int FDEPTH = 4;
  localparam int IAW    = 3;
  localparam int OAW    = 2;

`ifdef IOHUB_STATUS_EN
  localparam bit STATUS_EN = 1'b1;
`else
  localparam bit STATUS_EN = 1'b0;
`endif

  logic                     clk = 1'b0;
  logic                     rst;
  logic                     proc_req_in;
  logic [IAW-1:0]           addr_in;
  logic [NUBITS-1:0]        proc_in;
  logic                     proc_out_en;
  logic [OAW-1:0]           addr_out;
  logic [NUBITS-1:0]        proc_out;
  logic [NUIOIN*NUBITS-1:0] ext_in_data;
  logic [NUIOIN-1:0]        ext_in_valid;
  logic [NUIOIN-1:0]        ext_in_ready;
  logic [NUIOOU*NUBITS-1:0] ext_out_data;
  logic [NUIOOU-1:0]        ext_out_valid;
  logic [NUIOOU-1:0]        ext_out_ready;
  logic [NUIOIN-1:0]        unf_flag;
  logic [NUIOOU-1:0]        ovf_flag;

  proc_io_hub #(
    .NUBITS(NUBITS), .NUIOIN(NUIOIN), .NUIOOU(NUIOOU), .FDEPTH(FDEPTH)
  ) dut (
    .clk(clk), .rst(rst),
    .proc_req_in(proc_req_in), .addr_in(addr_in), .proc_in(proc_in),
    .proc_out_en(proc_out_en), .addr_out(addr_out), .proc_out(proc_out),
    .ext_in_data(ext_in_data), .ext_in_valid(ext_in_valid), .ext_in_ready(ext_in_ready),
    .ext_out_data(ext_out_data), .ext_out_valid(ext_out_valid), .ext_out_ready(ext_out_ready),
    .unf_flag(unf_flag), .ovf_flag(ovf_flag)
  );

  always #5 clk = ~clk;

  // Model state: each channel is a plain queue of words in arrival order
  logic [NUBITS-1:0] in_exp_q  [NUIOIN][$];
  logic [NUBITS-1:0] out_exp_q [NUIOOU][$];
  logic [NUBITS-1:0] hold_m    [NUIOIN];
  logic [NUIOIN-1:0] unf_m;
  logic [NUIOOU-1:0] ovf_m;
  bit                live = 1'b0;

  int n_pass  = 0;
  int n_total = 0;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
  endtask

  task automatic model_update();
    bit status_rd;
    if (rst) begin
      for (int i = 0; i < NUIOIN; i++) begin
        in_exp_q[i].delete();
        hold_m[i] = '0;
      end
      for (int j = 0; j < NUIOOU; j++) out_exp_q[j].delete();
      unf_m = '0;
      ovf_m = '0;
      live  = 1'b1;
      return;
    end
    status_rd = STATUS_EN && proc_req_in && (int'(addr_in) == NUIOIN);
    if (status_rd) begin
      unf_m = '0;
      ovf_m = '0;
    end
    for (int i = 0; i < NUIOIN; i++) begin
      bit was_full;
      was_full = (in_exp_q[i].size() == FDEPTH);
      if (proc_req_in && int'(addr_in) == i) begin
        if (in_exp_q[i].size() != 0) hold_m[i] = in_exp_q[i].pop_front();
        else unf_m[i] = 1'b1;
      end
      if (ext_in_valid[i] && !was_full) in_exp_q[i].push_back(ext_in_data[i*NUBITS +: NUBITS]);
    end
    for (int j = 0; j < NUIOOU; j++) begin
      if (out_exp_q[j].size() != 0 && ext_out_ready[j]) void'(out_exp_q[j].pop_front());
      if (proc_out_en && int'(addr_out) == j) begin
        if (out_exp_q[j].size() < FDEPTH) out_exp_q[j].push_back(proc_out);
        else ovf_m[j] = 1'b1;
      end
    end
  endtask

  task automatic compare();
    logic [NUIOIN-1:0]        e_ready;
    logic [NUIOOU-1:0]        e_valid;
    logic [NUIOOU*NUBITS-1:0] e_data, mask;
    logic [NUBITS-1:0]        e_pin;
    e_data = '0;
    mask   = '0;
    for (int i = 0; i < NUIOIN; i++) e_ready[i] = (in_exp_q[i].size() < FDEPTH);
    for (int j = 0; j < NUIOOU; j++) begin
      e_valid[j] = (out_exp_q[j].size() != 0);
      if (e_valid[j]) begin
        e_data[j*NUBITS +: NUBITS] = out_exp_q[j][0];
        mask[j*NUBITS +: NUBITS]   = '1;
      end
    end
    if (int'(addr_in) < NUIOIN)
      e_pin = (in_exp_q[addr_in].size() != 0) ? in_exp_q[addr_in][0] : hold_m[addr_in];
    else if (STATUS_EN && int'(addr_in) == NUIOIN)
      e_pin = NUBITS'({ovf_m, unf_m, ~e_valid, ~e_ready});
    else
      e_pin = '0;
    chk("m_ext_in_ready", 128'(ext_in_ready), 128'(e_ready));
    chk("m_ext_out_valid", 128'(ext_out_valid), 128'(e_valid));
    chk("m_ext_out_data", 128'(ext_out_data & mask), 128'(e_data));
    chk("m_proc_in", 128'(proc_in), 128'(e_pin));
    chk("m_unf_flag", 128'(unf_flag), 128'(unf_m));
    chk("m_ovf_flag", 128'(ovf_flag), 128'(ovf_m));
  endtask

  initial forever begin
    @(posedge clk);
    model_update();
  end

  initial forever begin
    @(negedge clk);
    if (live) compare();
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    proc_req_in   = 1'b0;
    addr_in       = '0;
    proc_out_en   = 1'b0;
    addr_out      = '0;
    proc_out      = '0;
    ext_in_data   = '0;
    ext_in_valid  = '0;
    ext_out_ready = '0;
  endtask

  initial begin
    int rd_exp[5];
    int dr_exp[4];
    rst = 1'b1;
    idle();
    repeat (2) tick();
    rst = 1'b0;
    #1;
    chk("reset_in_ready", 128'(ext_in_ready), 128'(4'hF));
    chk("reset_out_valid", 128'(ext_out_valid), 128'(4'h0));
    chk("reset_proc_in", 128'(proc_in), 128'(0));
    chk("reset_flags", 128'({unf_flag, ovf_flag}), 128'(0));

    // Fill input channel 1, then drain it from the core and read once more
    ext_in_valid = 4'b0010;
    for (int k = 0; k < 4; k++) begin
      ext_in_data[1*NUBITS +: NUBITS] = NUBITS'(10 * (k + 1));
      tick();
    end
    ext_in_valid = '0;
    #1;
    chk("in1_full_ready", 128'(ext_in_ready), 128'(4'b1101));
    rd_exp = '{10, 20, 30, 40, 40};
    proc_req_in = 1'b1;
    addr_in     = 3'd1;
    for (int k = 0; k < 5; k++) begin
      #1;
      chk("in1_read", 128'(proc_in), 128'(rd_exp[k]));
      tick();
    end
    proc_req_in = 1'b0;
    #1;
    chk("in1_unf", 128'(unf_flag), 128'(4'b0010));

    // Overfill output channel 2, then let the consumer drain it
    proc_out_en = 1'b1;
    addr_out    = 2'd2;
    for (int k = 0; k < 5; k++) begin
      proc_out = NUBITS'(100 + k);
      tick();
    end
    proc_out_en = 1'b0;
    #1;
    chk("out2_ovf", 128'(ovf_flag), 128'(4'b0100));
    chk("out2_valid", 128'(ext_out_valid), 128'(4'b0100));
    ext_out_ready = 4'b0100;
    for (int k = 0; k < 4; k++) begin
      #1;
      chk("out2_drain", 128'(ext_out_data[2*NUBITS +: NUBITS]), 128'(100 + k));
      tick();
    end
    #1;
    chk("out2_empty", 128'(ext_out_valid), 128'(4'b0000));
    ext_out_ready = '0;

    // Full output channel 0 accepts a write in the cycle the consumer pops
    proc_out_en = 1'b1;
    addr_out    = 2'd0;
    for (int k = 0; k < 4; k++) begin
      proc_out = NUBITS'(50 + k);
      tick();
    end
    proc_out      = NUBITS'(99);
    ext_out_ready = 4'b0001;
    #1;
    chk("out0_head", 128'(ext_out_data[0 +: NUBITS]), 128'(50));
    tick();
    proc_out_en = 1'b0;
    dr_exp = '{51, 52, 53, 99};
    for (int k = 0; k < 4; k++) begin
      #1;
      chk("out0_drain", 128'(ext_out_data[0 +: NUBITS]), 128'(dr_exp[k]));
      tick();
    end
    #1;
    chk("out0_no_ovf", 128'(ovf_flag[0]), 128'(0));
    chk("out0_empty", 128'(ext_out_valid), 128'(4'b0000));
    ext_out_ready = '0;

    // Push and read an empty input channel in the same cycle: no fall-through
    ext_in_valid = 4'b1000;
    ext_in_data[3*NUBITS +: NUBITS] = NUBITS'(7);
    proc_req_in = 1'b1;
    addr_in     = 3'd3;
    #1;
    chk("in3_same_cycle", 128'(proc_in), 128'(0));
    tick();
    ext_in_valid = '0;
    #1;
    chk("in3_unf", 128'(unf_flag), 128'(4'b1010));
    chk("in3_next_read", 128'(proc_in), 128'(7));
    tick();

    // Status address
    addr_in = 3'd4;
    #1;
    if (STATUS_EN) begin
      chk("status_word", 128'(proc_in), 128'(31'h4AF0));
      tick();
      #1;
      chk("status_after_clear", 128'(proc_in), 128'(31'h00F0));
      chk("status_flags_clear", 128'({unf_flag, ovf_flag}), 128'(0));
    end else begin
      chk("status_off_word", 128'(proc_in), 128'(0));
      tick();
      #1;
      chk("status_off_flags", 128'({unf_flag, ovf_flag}), 128'({4'b1010, 4'b0100}));
    end
    proc_req_in = 1'b0;
    tick();

    // Random traffic, occasional mid-run reset
    for (int c = 0; c < 3000; c++) begin
      rst          = ($urandom_range(0, 199) == 0);
      ext_in_valid = NUIOIN'($urandom);
      for (int i = 0; i < NUIOIN; i++) ext_in_data[i*NUBITS +: NUBITS] = NUBITS'($urandom);
      proc_req_in   = ($urandom_range(0, 2) != 0);
      addr_in       = IAW'($urandom_range(0, 7));
      proc_out_en   = ($urandom_range(0, 1) != 0);
      addr_out      = OAW'($urandom_range(0, NUIOOU - 1));
      proc_out      = NUBITS'($urandom);
      ext_out_ready = NUIOOU'($urandom);
      tick();
    end
    rst = 1'b0;
    idle();
    tick();
    tick();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
